// File: rtl/moving_sum_inverse_if.sv
// Valid/ready sample stream: master drives dat/vld, slave drives rdy.
// A beat transfers on any clock edge where vld and rdy are both high.
interface moving_sum_inverse_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] dat;
  logic             vld;
  logic             rdy;

  modport master (output dat, output vld, input rdy);
  modport slave  (input dat, input vld, output rdy);
endinterface

// File: rtl/moving_sum_inverse.sv
// Rebuilds x[n] from an N-tap moving sum: x[n] = s[n] - s[n-1] + x[n-N]; input reg -> compute -> output reg.
// Latency 2 cycles, 1 sample/cycle; a stalled output fills the input register and then drops input ready.
module moving_sum_inverse #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int SUM_WIDTH  = DATA_WIDTH + $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  moving_sum_inverse_if.slave  moving_sum_inverse__input_consumer,
  moving_sum_inverse_if.master moving_sum_inverse__output_producer
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [SUM_WIDTH-1:0]  in_reg;
  logic                  in_valid_reg;
  logic [DATA_WIDTH-1:0] out_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] hist [DEPTH];
  logic [IDX_W-1:0]      idx;
  logic [SUM_WIDTH-1:0]  prev;

  logic                  in_xfer;
  logic                  out_load_en;
  logic                  fire;
  logic [DATA_WIDTH-1:0] diff_lo;
  logic [SUM_WIDTH-DATA_WIDTH-1:0] diff_unused;
  logic [DATA_WIDTH-1:0] x_new;

  assign out_load_en = moving_sum_inverse__output_producer.rdy | ~out_valid_reg;
  assign fire        = in_valid_reg & out_load_en;

  // Ready is held low while reset is asserted so nothing is accepted into a clearing pipe.
  assign moving_sum_inverse__input_consumer.rdy = ~reset & (~in_valid_reg | fire);
  assign in_xfer = moving_sum_inverse__input_consumer.vld & moving_sum_inverse__input_consumer.rdy;

  // Upper difference bits are dropped: x[n] always fits DATA_WIDTH, so the low bits are exact mod 2^DATA_WIDTH.
  assign {diff_unused, diff_lo} = in_reg - prev;
  assign x_new = diff_lo + hist[idx];

  assign moving_sum_inverse__output_producer.dat = out_reg;
  assign moving_sum_inverse__output_producer.vld = out_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_reg        <= '0;
      in_valid_reg  <= 1'b0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      idx           <= '0;
      prev          <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      if (in_xfer) begin
        in_reg       <= moving_sum_inverse__input_consumer.dat;
        in_valid_reg <= 1'b1;
      end else if (fire) begin
        in_valid_reg <= 1'b0;
      end

      if (fire) begin
        out_reg       <= x_new;
        out_valid_reg <= 1'b1;
        hist[idx]     <= x_new;
        idx           <= idx + 1'b1;
        prev          <= in_reg;
      end else if (moving_sum_inverse__output_producer.rdy) begin
        out_valid_reg <= 1'b0;
      end
    end
  end
endmodule
